// File: rtl/led_pkg.sv
// Shared types for the LED frame scheduler: GRB colour word, FSM states and
// the 8-bit brightness scaling helper used by the colour pipeline.
package led_pkg;

    // One frame-buffer word, laid out as {G, R, B} to match the WS2812B wire order.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        FILL,
        DRAIN,
        FLUSH
    } state_t;

    // Scale one channel by the global brightness: (ch * brightness) >> 8.
    // The product is formed in 16 bits and the upper byte kept, so 255*255 maps to 254.
    function automatic logic [7:0] scale8(input logic [7:0] ch, input logic [7:0] brightness);
        logic [15:0] product;
        product = 16'(ch) * 16'(brightness);
        return product[15:8];
    endfunction

endpackage

// File: rtl/led_color_map.sv
// Two-stage colour pipeline: an 8-bit display level plus the frame brightness
// becomes a scaled GRB word. A blank entry produces black regardless of level,
// which is how padding writes for short frames travel in order with real ones.
module led_color_map
    import led_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_blank,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_level,
    input  logic [7:0]        in_brightness,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output grb_t              out_color,
    output logic              busy
);

    logic              s1_valid;
    logic              s1_blank;
    logic [ADDR_W-1:0] s1_addr;
    logic [7:0]        s1_level;
    logic [7:0]        s1_brightness;

    // Stage 1 registers the incoming entry so the multiplies start from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_blank      <= 1'b0;
            s1_addr       <= '0;
            s1_level      <= '0;
            s1_brightness <= '0;
        end else begin
            s1_valid      <= in_valid;
            s1_blank      <= in_blank;
            s1_addr       <= in_addr;
            s1_level      <= in_level;
            s1_brightness <= in_brightness;
        end
    end

    // Stage 2 maps level to green-to-red, scales both channels and registers the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_color <= '0;
        end else begin
            out_valid <= s1_valid;
            out_addr  <= s1_addr;
            if (s1_blank) begin
                out_color <= '0;
            end else begin
                out_color.g <= scale8(8'(8'd255 - s1_level), s1_brightness);
                out_color.r <= scale8(s1_level, s1_brightness);
                out_color.b <= 8'd0;
            end
        end
    end

    assign busy = s1_valid | out_valid;

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame scheduler between the spectrum magnitude path and the WS2812B serializer.
// On each frame tick it accepts one level per LED, pads short frames with black,
// discards the tail of long frames, and reports framing problems on a sticky flag.
// Optional build macro: LED_FRAME_SCHEDULER_PEAK_HOLD_EN adds per-LED peak hold
// with a DECAY step per accepted frame.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int STRIP_LEN    = 120,
    parameter int LEVEL_BITS   = 8,
    parameter int COLOR_BITS   = 24,
    parameter int FRAME_CYCLES = 1666667
`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
    ,
    parameter int DECAY        = 4
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LEVEL_BITS-1:0]        s_level,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    input  logic [7:0]                   brightness,
    output logic                         write_en,
    output logic [$clog2(STRIP_LEN)-1:0] write_addr,
    output logic [COLOR_BITS-1:0]        din,
    output logic                         frame_done,
    output logic                         frame_err
);

    localparam int ADDR_W = $clog2(STRIP_LEN);
    localparam int CNT_W  = $clog2(FRAME_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(STRIP_LEN - 1);
    localparam logic [CNT_W-1:0]  TICK_COUNT = CNT_W'(FRAME_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  tick_count;
    logic              tick;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        frame_brightness;
    logic              handshake;
    logic              push_valid;
    logic              push_blank;
    logic              pipe_busy;
    logic [7:0]        level8;
    logic [7:0]        display_level;
    logic              short_frame;
    logic              long_frame;
    logic              missed_tick;
    grb_t              pipe_color;

    // Normalise the incoming level to 8 bits: keep the MSBs of wide levels, zero-fill narrow ones.
    generate
        if (LEVEL_BITS >= 8) begin : g_level_msb
            assign level8 = s_level[LEVEL_BITS-1 -: 8];
        end else begin : g_level_pad
            assign level8 = {s_level, {(8 - LEVEL_BITS){1'b0}}};
        end
    endgenerate

    // Free-running frame tick counter; it never stops, so a late frame simply misses ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_count <= '0;
        end else if (tick) begin
            tick_count <= '0;
        end else begin
            tick_count <= tick_count + 1'b1;
        end
    end

    assign tick      = (tick_count == TICK_COUNT);
    assign handshake = s_valid & s_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision: frame end is judged by where s_last lands relative to the last LED.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tick) state_next = ACCEPT;
            end
            ACCEPT: begin
                if (handshake) begin
                    if (s_last) begin
                        state_next = (idx == LAST_IDX) ? FLUSH : FILL;
                    end else if (idx == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end
            FILL: begin
                if (idx == LAST_IDX) state_next = FLUSH;
            end
            DRAIN: begin
                if (handshake && s_last) state_next = FLUSH;
            end
            FLUSH: begin
                if (!pipe_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State-derived outputs: stream ready, pipe pushes and the end-of-frame pulse.
    always_comb begin
        s_ready    = 1'b0;
        push_valid = 1'b0;
        push_blank = 1'b0;
        frame_done = 1'b0;
        case (state)
            ACCEPT: begin
                s_ready    = 1'b1;
                push_valid = handshake;
            end
            FILL: begin
                push_valid = 1'b1;
                push_blank = 1'b1;
            end
            DRAIN: begin
                s_ready = 1'b1;
            end
            FLUSH: begin
                frame_done = ~pipe_busy;
            end
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

    assign short_frame = (state == ACCEPT) & handshake & s_last & (idx != LAST_IDX);
    assign long_frame  = (state == ACCEPT) & handshake & ~s_last & (idx == LAST_IDX);
    assign missed_tick = tick & (state != IDLE);

    // LED index, per-frame brightness snapshot and the sticky framing error.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx              <= '0;
            frame_brightness <= '0;
            frame_err        <= 1'b0;
        end else begin
            if (state == IDLE && tick) begin
                idx              <= '0;
                frame_brightness <= brightness;
            end else if (state == ACCEPT && handshake && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end else if (state == FILL && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
            if (short_frame || long_frame || missed_tick) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
    logic [7:0] peak [STRIP_LEN];
    logic [7:0] decayed_peak;

    // Decay the stored peak by one step, then display whichever is higher: it or the new level.
    always_comb begin
        decayed_peak  = (peak[idx] >= 8'(DECAY)) ? 8'(peak[idx] - 8'(DECAY)) : 8'd0;
        display_level = (level8 > decayed_peak) ? level8 : decayed_peak;
    end

    // Peaks update only for LEDs written from real levels; padded LEDs keep theirs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STRIP_LEN; i++) begin
                peak[i] <= 8'd0;
            end
        end else if (push_valid && !push_blank) begin
            peak[idx] <= display_level;
        end
    end
`else
    assign display_level = level8;
`endif

    led_color_map #(
        .ADDR_W (ADDR_W)
    ) u_color_map (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (push_valid),
        .in_blank      (push_blank),
        .in_addr       (idx),
        .in_level      (display_level),
        .in_brightness (frame_brightness),
        .out_valid     (write_en),
        .out_addr      (write_addr),
        .out_color     (pipe_color),
        .busy          (pipe_busy)
    );

    assign din = COLOR_BITS'(pipe_color);

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler with a small strip and short frames.
// A frame-level reference model derives every expected write, its cycle and the
// frame_done cycle from the accepted levels; the peak-hold scenario runs only when
// LED_FRAME_SCHEDULER_PEAK_HOLD_EN is defined.
module tb_led_frame_scheduler;

    localparam int STRIP  = 8;
    localparam int FRAMEC = 100;
    localparam int DECAYV = 4;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic [23:0] din;
    } wr_t;

    typedef struct {
        int cyc;
        int level;
        bit last;
    } hs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_level = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  brightness = '0;
    logic        write_en;
    logic [2:0]  write_addr;
    logic [23:0] din;
    logic        frame_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_err = 0;
    int exp_done = -1;
    int stim[STRIP + 4];
    wr_t exp_q[$];
    wr_t wr_q[$];
    hs_t hs_q[$];
    int  done_q[$];
`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
    int model_peak[STRIP];
`endif

    led_frame_scheduler #(
        .STRIP_LEN    (STRIP),
        .LEVEL_BITS   (8),
        .COLOR_BITS   (24),
        .FRAME_CYCLES (FRAMEC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_level    (s_level),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .brightness (brightness),
        .write_en   (write_en),
        .write_addr (write_addr),
        .din        (din),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Cycle index, advanced on every active edge.
    always @(posedge clk) cyc++;

    // Monitor on the falling edge: log handshakes, writes and frame_done pulses with their cycle.
    always @(negedge clk) begin
        if (!reset && s_valid && s_ready) hs_q.push_back('{cyc, int'(s_level), s_last});
        if (write_en) wr_q.push_back('{cyc, write_addr, din});
        if (frame_done) done_q.push_back(cyc);
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [23:0] color(input int l, input int br);
        int g;
        int r;
        g = ((255 - l) * br) / 256;
        r = (l * br) / 256;
        return {8'(g), 8'(r), 8'd0};
    endfunction

    // Reference model for one frame: from the logged handshakes, derive the writes and frame_done.
    task automatic model_frame(input int br);
        int p;
        int n_disp;
        int lvl;
`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
        int dec;
`endif
        exp_q.delete();
        exp_done = -1;
        if (hs_q.size() == 0) return;
        p = hs_q.size() - 1;
        for (int i = 0; i < hs_q.size(); i++) begin
            if (hs_q[i].last) begin
                p = i;
                break;
            end
        end
        n_disp = (p + 1 < STRIP) ? p + 1 : STRIP;
        for (int i = 0; i < n_disp; i++) begin
            lvl = hs_q[i].level;
`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
            dec = model_peak[i] - DECAYV;
            if (dec < 0) dec = 0;
            if (dec > lvl) lvl = dec;
            model_peak[i] = lvl;
`endif
            exp_q.push_back('{hs_q[i].cyc + 2, 3'(i), color(lvl, br)});
        end
        for (int j = p + 1; j < STRIP; j++) begin
            exp_q.push_back('{hs_q[p].cyc + 2 + (j - p), 3'(j), 24'd0});
        end
        if (p != STRIP - 1) model_err = 1;
        exp_done = exp_q[$].cyc + 1;
        if (hs_q[p].cyc + 1 > exp_done) exp_done = hs_q[p].cyc + 1;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_level = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        hs_q.delete();
        wr_q.delete();
        done_q.delete();
        model_err = 0;
`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
        foreach (model_peak[i]) model_peak[i] = 0;
`endif
    endtask

    // Offer n levels from stim[]; s_last on element last_at (-1 for none). Optional mid-frame brightness change.
    task automatic send_stream(input int n, input int last_at, input bit rand_valid, input int br_after);
        int i = 0;
        int guard = 0;
        bit hs;
        while (i < n) begin
            if (guard > 3 * FRAMEC + 40 * n) begin
                checks++;
                errors++;
                $display("[TB] FAIL stream_timeout: accepted %0d levels, expected %0d", i, n);
                break;
            end
            s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_level = 8'(stim[i]);
            s_last  = (i == last_at);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                if (br_after >= 0) brightness = 8'(br_after);
                i++;
            end
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input int last_at, input bit rand_valid, input int br_after);
        int w = 0;
        hs_q.delete();
        wr_q.delete();
        done_q.delete();
        send_stream(n, last_at, rand_valid, br_after);
        while (done_q.size() == 0 && w < 60) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus_levels(input int mode);
        for (int i = 0; i < STRIP + 4; i++) begin
            stim[i] = (mode == 0) ? i * 32 : (mode == 1) ? 255 : int'($urandom_range(0, 255));
        end
    endtask

    task automatic test_reset();
        int n = 0;
        brightness = 8'd255;
        apply_reset();
        checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_en: got %b, expected 0", write_en); end
        checks++; if (write_addr !== 3'd0) begin errors++; $display("[TB] FAIL reset_write_addr: got %0d, expected 0", write_addr); end
        checks++; if (din !== 24'd0) begin errors++; $display("[TB] FAIL reset_din: got %h, expected 000000", din); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b, expected 0", frame_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b, expected 0", frame_err); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b, expected 0", s_ready); end
        while (s_ready !== 1'b1 && n < FRAMEC + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != FRAMEC) begin errors++; $display("[TB] FAIL reset_first_tick: ready after %0d cycles, expected %0d", n, FRAMEC); end
    endtask

    task automatic test_full_frame();
        applyStimulus_levels(0);
        run_frame(STRIP, STRIP - 1, 1'b0, -1);
        model_frame(255);
        checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL full_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < wr_q.size()) begin
            checks++;
            if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].din !== exp_q[k].din || wr_q[k].cyc != exp_q[k].cyc) begin
                errors++;
                $display("[TB] FAIL full_write%0d: got addr=%0d din=%h cyc=%0d, expected addr=%0d din=%h cyc=%0d", k, wr_q[k].addr, wr_q[k].din, wr_q[k].cyc, exp_q[k].addr, exp_q[k].din, exp_q[k].cyc);
            end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("[TB] FAIL full_done: got %0d pulses (first cyc %0d), expected 1 at cyc %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done); end
        checks++; if (frame_err !== 1'(model_err)) begin errors++; $display("[TB] FAIL full_err: got %b, expected %0d", frame_err, model_err); end
    endtask

    task automatic test_backpressure();
        int br;
        for (int f = 0; f < 4; f++) begin
            br = (f == 0) ? 128 : int'($urandom_range(0, 255));
            brightness = 8'(br);
            applyStimulus_levels((f == 0) ? 1 : 2);
            run_frame(STRIP, STRIP - 1, 1'b1, int'($urandom_range(0, 255)));
            model_frame(br);
            checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL bp%0d_count: got %0d writes, expected %0d", f, wr_q.size(), exp_q.size()); end
            foreach (exp_q[k]) if (k < wr_q.size()) begin
                checks++;
                if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].din !== exp_q[k].din || wr_q[k].cyc != exp_q[k].cyc) begin
                    errors++;
                    $display("[TB] FAIL bp%0d_write%0d: got addr=%0d din=%h cyc=%0d, expected addr=%0d din=%h cyc=%0d", f, k, wr_q[k].addr, wr_q[k].din, wr_q[k].cyc, exp_q[k].addr, exp_q[k].din, exp_q[k].cyc);
                end
            end
            checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("[TB] FAIL bp%0d_done: got %0d pulses, expected 1 at cyc %0d", f, done_q.size(), exp_done); end
            checks++; if (frame_err !== 1'(model_err)) begin errors++; $display("[TB] FAIL bp%0d_err: got %b, expected %0d", f, frame_err, model_err); end
        end
    endtask

    task automatic test_short_frame();
        int br = int'($urandom_range(1, 255));
        brightness = 8'(br);
        applyStimulus_levels(2);
        run_frame(5, 4, 1'b1, -1);
        model_frame(br);
        checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL short_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < wr_q.size()) begin
            checks++;
            if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].din !== exp_q[k].din || wr_q[k].cyc != exp_q[k].cyc) begin
                errors++;
                $display("[TB] FAIL short_write%0d: got addr=%0d din=%h cyc=%0d, expected addr=%0d din=%h cyc=%0d", k, wr_q[k].addr, wr_q[k].din, wr_q[k].cyc, exp_q[k].addr, exp_q[k].din, exp_q[k].cyc);
            end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("[TB] FAIL short_done: got %0d pulses, expected 1 at cyc %0d", done_q.size(), exp_done); end
        checks++; if (frame_err !== 1'(model_err)) begin errors++; $display("[TB] FAIL short_err: got %b, expected %0d", frame_err, model_err); end
    endtask

    task automatic test_long_frame();
        int br = int'($urandom_range(1, 255));
        brightness = 8'(br);
        applyStimulus_levels(2);
        run_frame(STRIP + 3, STRIP + 2, 1'b1, -1);
        model_frame(br);
        checks++; if (hs_q.size() != STRIP + 3) begin errors++; $display("[TB] FAIL long_accepted: got %0d handshakes, expected %0d", hs_q.size(), STRIP + 3); end
        checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL long_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < wr_q.size()) begin
            checks++;
            if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].din !== exp_q[k].din || wr_q[k].cyc != exp_q[k].cyc) begin
                errors++;
                $display("[TB] FAIL long_write%0d: got addr=%0d din=%h cyc=%0d, expected addr=%0d din=%h cyc=%0d", k, wr_q[k].addr, wr_q[k].din, wr_q[k].cyc, exp_q[k].addr, exp_q[k].din, exp_q[k].cyc);
            end
        end
        checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("[TB] FAIL long_done: got %0d pulses, expected 1 at cyc %0d", done_q.size(), exp_done); end
        checks++; if (frame_err !== 1'(model_err)) begin errors++; $display("[TB] FAIL long_err: got %b, expected %0d", frame_err, model_err); end
    endtask

    task automatic test_missed_tick();
        int w = 0;
        int rst_cyc;
        int late = 0;
        int br = int'($urandom_range(1, 255));
        apply_reset();
        while (s_ready !== 1'b1 && w < FRAMEC + 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (FRAMEC + 5) @(posedge clk);
        #1;
        model_err = 1;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL missed_err: got %b, expected 1", frame_err); end
        checks++; if (wr_q.size() != 0) begin errors++; $display("[TB] FAIL missed_writes: got %0d writes, expected 0", wr_q.size()); end
        applyStimulus_levels(2);
        send_stream(3, -1, 1'b0, -1);
        reset = 1'b1;
        rst_cyc = cyc;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({write_en, write_addr, din, frame_done, frame_err, s_ready} !== '0) begin errors++; $display("[TB] FAIL midreset_outputs: got en=%b addr=%0d din=%h done=%b err=%b rdy=%b, expected all 0", write_en, write_addr, din, frame_done, frame_err, s_ready); end
        foreach (wr_q[k]) if (wr_q[k].cyc > rst_cyc) late++;
        checks++; if (late != 0) begin errors++; $display("[TB] FAIL midreset_late_writes: got %0d, expected 0", late); end
        brightness = 8'(br);
        apply_reset();
        applyStimulus_levels(2);
        run_frame(STRIP, STRIP - 1, 1'b1, -1);
        model_frame(br);
        checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL after_reset_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < wr_q.size()) begin
            checks++;
            if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].din !== exp_q[k].din || wr_q[k].cyc != exp_q[k].cyc) begin
                errors++;
                $display("[TB] FAIL after_reset_write%0d: got addr=%0d din=%h cyc=%0d, expected addr=%0d din=%h cyc=%0d", k, wr_q[k].addr, wr_q[k].din, wr_q[k].cyc, exp_q[k].addr, exp_q[k].din, exp_q[k].cyc);
            end
        end
        checks++; if (frame_err !== 1'(model_err)) begin errors++; $display("[TB] FAIL after_reset_err: got %b, expected %0d", frame_err, model_err); end
    endtask

`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
    task automatic test_peak_hold();
        brightness = 8'd255;
        apply_reset();
        for (int f = 0; f < 2; f++) begin
            applyStimulus_levels(2);
            stim[0] = (f == 0) ? 200 : 0;
            run_frame(STRIP, STRIP - 1, 1'b0, -1);
            model_frame(255);
            checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL peak%0d_count: got %0d writes, expected %0d", f, wr_q.size(), exp_q.size()); end
            foreach (exp_q[k]) if (k < wr_q.size()) begin
                checks++;
                if (wr_q[k].addr !== exp_q[k].addr || wr_q[k].din !== exp_q[k].din || wr_q[k].cyc != exp_q[k].cyc) begin
                    errors++;
                    $display("[TB] FAIL peak%0d_write%0d: got addr=%0d din=%h cyc=%0d, expected addr=%0d din=%h cyc=%0d", f, k, wr_q[k].addr, wr_q[k].din, wr_q[k].cyc, exp_q[k].addr, exp_q[k].din, exp_q[k].cyc);
                end
            end
        end
        checks++; if (wr_q.size() == 0 || wr_q[0].din !== color(196, 255)) begin errors++; $display("[TB] FAIL peak_addr0: got %h, expected %h", (wr_q.size() > 0) ? wr_q[0].din : 24'd0, color(196, 255)); end
    endtask
`endif

    initial begin
        $display("[TB] starting led_frame_scheduler bench");
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_missed_tick();
`ifdef LED_FRAME_SCHEDULER_PEAK_HOLD_EN
        test_peak_hold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
